// File: rtl/tick_counter_sequencer.sv
// Prescaled up-counter with start/pause/stop/load run control.
// One-shot or wrap-around counting on a DIV-cycle tick enable.
module tick_counter_sequencer #(
  parameter int DIV   = 50000000,
  parameter int CW    = 28,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pause,
  input  logic             stop,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  input  logic             mode,
  output logic [WIDTH-1:0] q,
  output logic             tick,
  output logic             done,
  output logic             wrap,
  output logic             busy,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CW-1:0] PMAX = CW'(DIV - 1);

  state_t           st;
  state_t           st_n;
  logic [CW-1:0]    pcnt;
  logic [CW-1:0]    pcnt_n;
  logic [WIDTH-1:0] q_n;
  logic             done_n;
  logic             wrap_n;

  assign tick  = (st == RUN) && (pcnt == PMAX);
  assign busy  = (st == RUN) || (st == PAUSE);
  assign state = st;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st   <= IDLE;
      q    <= '0;
      pcnt <= '0;
      done <= 1'b0;
      wrap <= 1'b0;
    end else begin
      st   <= st_n;
      q    <= q_n;
      pcnt <= pcnt_n;
      done <= done_n;
      wrap <= wrap_n;
    end
  end

  always_comb begin
    st_n   = st;
    q_n    = q;
    pcnt_n = pcnt;
    done_n = 1'b0;
    wrap_n = 1'b0;
    unique case (st)
      RUN:     pcnt_n = tick ? '0 : pcnt + 1'b1;
      PAUSE:   pcnt_n = pcnt;
      default: pcnt_n = '0;
    endcase
    if (stop) begin
      st_n   = IDLE;
      q_n    = '0;
      pcnt_n = '0;
    end else if (load) begin
      q_n    = load_val;
      pcnt_n = '0;
      if (st == DONE)
        st_n = IDLE;
    end else begin
      unique case (st)
        IDLE: begin
          if (start) begin
            st_n   = RUN;
            pcnt_n = '0;
          end
        end
        RUN: begin
          if (tick) begin
            if (q != limit) begin
              q_n = q + 1'b1;
            end else if (!mode) begin
              st_n   = DONE;
              done_n = 1'b1;
            end else begin
              q_n    = '0;
              wrap_n = 1'b1;
            end
          end
          // a same-edge DONE transition outranks pause
          if (pause && st_n == RUN)
            st_n = PAUSE;
        end
        PAUSE: begin
          if (start)
            st_n = RUN;
        end
        DONE: begin
          if (start) begin
            st_n   = RUN;
            q_n    = '0;
            pcnt_n = '0;
          end
        end
        default: st_n = IDLE;
      endcase
    end
  end

endmodule
